// File: rtl/simd_perm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : simd_perm_pkg
// Description : Shared defaults, permute-mode encoding and lane-index width
//               helper for the SIMD permute pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
package simd_perm_pkg;

    localparam int C_DEF_DATA_WIDTH = 64;
    localparam int C_DEF_NUM_LANES  = 32;
    localparam int C_DEF_NUM_CFG    = 4;

    // Per-vector operating mode carried on in_mode
    typedef enum logic {
        PERM = 1'b0,
        ROT  = 1'b1
    } perm_mode_e;

    // Bits needed to address n entries (never below one bit)
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/simd_lane_xbar.sv
`default_nettype none
// ============================================================================
// Module      : simd_lane_xbar
// Description : Combinational NUM_LANES-to-NUM_LANES crossbar; every output
//               lane independently picks one input lane via its select field.
// Revision    : 1.0 - initial release
// ============================================================================
module simd_lane_xbar
    import simd_perm_pkg::*;
#(
    parameter int DATA_WIDTH = C_DEF_DATA_WIDTH,
    parameter int NUM_LANES  = C_DEF_NUM_LANES,
    parameter int LANE_W     = idx_width(NUM_LANES)
) (
    input  logic [NUM_LANES*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_LANES*LANE_W-1:0]     sel,
    output logic [NUM_LANES*DATA_WIDTH-1:0] out_data
);

    logic [DATA_WIDTH-1:0] w_lane [NUM_LANES];

    for (genvar j = 0; j < NUM_LANES; j++) begin : g_unpack
        assign w_lane[j] = in_data[j*DATA_WIDTH +: DATA_WIDTH];
    end

    // Each destination lane is a plain mux over all source lanes, so
    // repeated select values simply broadcast the same source.
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        assign out_data[i*DATA_WIDTH +: DATA_WIDTH] = w_lane[sel[i*LANE_W +: LANE_W]];
    end

endmodule
`default_nettype wire

// File: rtl/simd_permute_pipe.sv
`default_nettype none
// ============================================================================
// Module      : simd_permute_pipe
// Description : Two-stage valid/ready SIMD lane permute. Stage 1 captures the
//               vector with its per-lane source indices (table lookup or
//               rotate); stage 2 holds the crossbar result. Includes a
//               writable per-pattern index table and a transfer counter.
// Revision    : 1.0 - initial release
// ============================================================================
module simd_permute_pipe
    import simd_perm_pkg::*;
#(
    parameter  int DATA_WIDTH = C_DEF_DATA_WIDTH,
    parameter  int NUM_LANES  = C_DEF_NUM_LANES,
    parameter  int NUM_CFG    = C_DEF_NUM_CFG,
    localparam int LW         = idx_width(NUM_LANES),
    localparam int CW         = idx_width(NUM_CFG),
    localparam int VW         = NUM_LANES * DATA_WIDTH
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          cfg_valid,
    input  logic [CW-1:0] cfg_entry,
    input  logic [LW-1:0] cfg_lane,
    input  logic [LW-1:0] cfg_idx,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_mode,
    input  logic [CW-1:0] in_sel,
    input  logic [LW-1:0] in_rot,
    input  logic [VW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [VW-1:0] out_data,
    output logic [15:0]   xfer_count
);

    logic [LW-1:0]           tbl_q [NUM_CFG][NUM_LANES];
    logic [LW-1:0]           tbl_d [NUM_CFG][NUM_LANES];
    logic                    s1_valid_q, s1_valid_d;
    logic [VW-1:0]           s1_data_q,  s1_data_d;
    logic [NUM_LANES*LW-1:0] s1_sel_q,   s1_sel_d;
    logic                    s2_valid_q, s2_valid_d;
    logic [VW-1:0]           s2_data_q,  s2_data_d;
    logic [15:0]             xfer_q,     xfer_d;

    logic                    w_s2_load;
    logic                    w_xfer;
    logic [NUM_LANES*LW-1:0] w_src_sel;
    logic [VW-1:0]           w_xbar_out;

    // Stage 2 can take a new vector when empty or draining this cycle;
    // stage 1 frees up when empty or when its content moves into stage 2.
    assign w_s2_load  = !s2_valid_q || out_ready;
    assign in_ready   = !reset && (!s1_valid_q || w_s2_load);
    assign out_valid  = s2_valid_q && !reset;
    assign w_xfer     = out_valid && out_ready;
    assign out_data   = s2_data_q;
    assign xfer_count = xfer_q;

    // Resolve per-lane source indices at acceptance from the current table
    // contents, so a same-cycle or later cfg write cannot touch this vector.
    always_comb begin
        w_src_sel = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (perm_mode_e'(in_mode) == ROT) begin
                w_src_sel[i*LW +: LW] = LW'(i) + in_rot;
            end else begin
                w_src_sel[i*LW +: LW] = tbl_q[in_sel][i];
            end
        end
    end

    // Index-table update: cfg writes land regardless of the data handshake
    always_comb begin
        tbl_d = tbl_q;
        if (cfg_valid) begin
            tbl_d[cfg_entry][cfg_lane] = cfg_idx;
        end
    end

    // Pipeline advance and transfer counting
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
        s1_sel_d   = s1_sel_q;
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        xfer_d     = xfer_q + {15'd0, w_xfer};

        if (in_ready) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_data_d = in_data;
                s1_sel_d  = w_src_sel;
            end
        end

        if (w_s2_load) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_data_d = w_xbar_out;
            end
        end
    end

    simd_lane_xbar #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_LANES  (NUM_LANES),
        .LANE_W     (LW)
    ) u_xbar (
        .in_data  (s1_data_q),
        .sel      (s1_sel_q),
        .out_data (w_xbar_out)
    );

    // State registers; reset drops in-flight vectors and restores identity
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_sel_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            xfer_q     <= '0;
            for (int e = 0; e < NUM_CFG; e++) begin
                for (int l = 0; l < NUM_LANES; l++) begin
                    tbl_q[e][l] <= LW'(l);
                end
            end
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s1_sel_q   <= s1_sel_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            xfer_q     <= xfer_d;
            tbl_q      <= tbl_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_simd_permute_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_simd_permute_pipe
// Description : Self-checking bench for simd_permute_pipe with a queue-based
//               reference model of the table, the in-flight vectors and the
//               transfer counter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_simd_permute_pipe;

    localparam int DW = 64;
    localparam int NL = 32;
    localparam int NC = 4;
    localparam int VW = NL * DW;

    typedef logic [VW-1:0] vec_t;

    logic          clock = 1'b0;
    logic          reset;
    logic          cfg_valid;
    logic [1:0]    cfg_entry;
    logic [4:0]    cfg_lane;
    logic [4:0]    cfg_idx;
    logic          in_valid;
    logic          in_ready;
    logic          in_mode;
    logic [1:0]    in_sel;
    logic [4:0]    in_rot;
    vec_t          in_data;
    logic          out_valid;
    logic          out_ready;
    vec_t          out_data;
    logic [15:0]   xfer_count;

    always #5 clock = ~clock;

    simd_permute_pipe #(
        .DATA_WIDTH (DW),
        .NUM_LANES  (NL),
        .NUM_CFG    (NC)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .cfg_valid  (cfg_valid),
        .cfg_entry  (cfg_entry),
        .cfg_lane   (cfg_lane),
        .cfg_idx    (cfg_idx),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_mode    (in_mode),
        .in_sel     (in_sel),
        .in_rot     (in_rot),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .xfer_count (xfer_count)
    );

    // Reference model state
    int          mtab [NC][NL];
    vec_t        exp_q [$];
    int          acc_q [$];
    int          cyc = 0;
    logic [15:0] exp_xfer = 16'd0;
    bit          hold_pend = 1'b0;
    vec_t        held;
    vec_t        last_out;
    bit          got_out;
    bit          acc_flag;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic chk_vec(input string tag, input vec_t got, input vec_t exp);
        int k = 0;
        for (int i = NL - 1; i >= 0; i--)
            if (got[i*DW +: DW] !== exp[i*DW +: DW]) k = i;
        chk($sformatf("%s[lane%0d]", tag, k), got[k*DW +: DW], exp[k*DW +: DW]);
    endtask

    function automatic vec_t rand_vec();
        vec_t v;
        for (int i = 0; i < NL * 2; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [DW-1:0] lane(input vec_t v, input int i);
        return v[i*DW +: DW];
    endfunction

    function automatic vec_t model_perm(input vec_t d, input bit mode, input int sel, input int rot);
        vec_t r;
        int   src;
        for (int i = 0; i < NL; i++) begin
            src = mode ? (i + rot) % NL : mtab[sel][i];
            r[i*DW +: DW] = d[src*DW +: DW];
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int e = 0; e < NC; e++)
            for (int l = 0; l < NL; l++) mtab[e][l] = l;
        exp_q.delete();
        acc_q.delete();
        exp_xfer  = 16'd0;
        hold_pend = 1'b0;
    endtask

    // One clock cycle: observe at the falling edge, update the model, then
    // return just after the rising edge so the caller can drive new inputs.
    task automatic tick();
        bit ev;
        vec_t e;
        got_out  = 1'b0;
        acc_flag = 1'b0;
        @(negedge clock);
        if (reset) begin
            chk("rst_in_ready", in_ready, 0);
            chk("rst_out_valid", out_valid, 0);
            model_reset();
        end else begin
            ev = (exp_q.size() > 0) && (cyc >= acc_q[0] + 2);
            chk("in_ready", in_ready, (exp_q.size() < 2) || out_ready);
            chk("out_valid", out_valid, ev);
            if (hold_pend) chk_vec("hold_data", out_data, held);
            if (out_valid && out_ready) begin
                chk("xfer_count", xfer_count, exp_xfer);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    void'(acc_q.pop_front());
                    chk_vec("out_data", out_data, e);
                end
                last_out = out_data;
                got_out  = 1'b1;
                exp_xfer = exp_xfer + 16'd1;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model_perm(in_data, in_mode, in_sel, in_rot));
                acc_q.push_back(cyc);
                acc_flag = 1'b1;
            end
            if (cfg_valid) mtab[cfg_entry][cfg_lane] = cfg_idx;
            hold_pend = out_valid && !out_ready;
            held      = out_data;
        end
        @(posedge clock);
        #1;
        cyc++;
    endtask

    // Offer one vector into an empty pipeline and wait for it to come out
    task automatic send(input vec_t d, input bit mode, input int sel, input int rot, output vec_t res);
        int n = 0;
        in_data  = d;
        in_mode  = mode;
        in_sel   = 2'(sel);
        in_rot   = 5'(rot);
        in_valid = 1'b1;
        tick();
        in_valid  = 1'b0;
        cfg_valid = 1'b0;
        while (!got_out && n < 10) begin
            tick();
            n++;
        end
        chk("send_done", got_out, 1);
        res = last_out;
    endtask

    task automatic cfg_set(input int e, input int l, input int idx);
        cfg_valid = 1'b1;
        cfg_entry = 2'(e);
        cfg_lane  = 5'(l);
        cfg_idx   = 5'(idx);
    endtask

    initial begin
        vec_t vin, vin2, vres, vexp;
        int   nacc;
        int   n;
        bit   saw_ffff;

        reset = 1'b1; cfg_valid = 1'b0; cfg_entry = '0; cfg_lane = '0; cfg_idx = '0;
        in_valid = 1'b0; in_mode = 1'b0; in_sel = '0; in_rot = '0; in_data = '0;
        out_ready = 1'b1;
        model_reset();

        // Reset state
        tick();
        tick();
        reset = 1'b0;
        chk("rst_xfer_count", xfer_count, 0);
        chk_vec("rst_out_data", out_data, '0);
        chk("rst_out_valid_hold", out_valid, 0);

        // Identity pass-through with latency check
        for (int i = 0; i < NL; i++) vin[i*DW +: DW] = DW'(i);
        in_data = vin; in_mode = 1'b0; in_sel = 2'd0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("lat_edge1_valid", out_valid, 0);
        tick();
        chk("lat_edge2_valid", out_valid, 1);
        tick();
        chk_vec("identity", last_out, vin);
        chk("xfer_after_first", xfer_count, 1);

        // Rotate by 3
        vin = rand_vec();
        send(vin, 1'b1, 0, 3, vres);
        chk("rot3_lane0", lane(vres, 0), lane(vin, 3));
        chk("rot3_lane31", lane(vres, 31), lane(vin, 2));

        // Table 1 becomes a reversal; final write (lane 0) coincides with acceptance
        for (int l = NL - 1; l >= 1; l--) begin
            cfg_set(1, l, NL - 1 - l);
            tick();
        end
        cfg_set(1, 0, NL - 1);
        vin = rand_vec();
        send(vin, 1'b0, 1, 0, vres);
        chk("rev_race_lane0", lane(vres, 0), lane(vin, 0));
        chk("rev_race_lane1", lane(vres, 1), lane(vin, 30));
        vin2 = rand_vec();
        send(vin2, 1'b0, 1, 0, vres);
        for (int i = 0; i < NL; i++) vexp[i*DW +: DW] = lane(vin2, NL - 1 - i);
        chk_vec("rev_full", vres, vexp);

        // Broadcast lane 7 through table 2
        for (int l = 0; l < NL; l++) begin
            cfg_set(2, l, 7);
            tick();
        end
        cfg_valid = 1'b0;
        vin = rand_vec();
        send(vin, 1'b0, 2, 0, vres);
        for (int i = 0; i < NL; i++) vexp[i*DW +: DW] = lane(vin, 7);
        chk_vec("broadcast", vres, vexp);

        // Back-pressure: continuous offers with out_ready low for 5 cycles
        nacc = 0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            in_data = rand_vec(); in_mode = 1'($urandom); in_sel = 2'($urandom); in_rot = 5'($urandom);
            tick();
            if (acc_flag) nacc++;
        end
        chk("stall_accepts", nacc, 2);
        chk("stall_in_ready", in_ready, 0);
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            in_data = rand_vec(); in_mode = 1'($urandom); in_sel = 2'($urandom); in_rot = 5'($urandom);
            tick();
        end
        in_valid = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        chk("stall_drained", exp_q.size(), 0);

        // Reset with both stages full
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_data = rand_vec(); in_mode = 1'b0; in_sel = 2'd1;
            tick();
        end
        reset = 1'b1;
        tick();
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        chk("rst_mid_out_valid", out_valid, 0);
        chk("rst_mid_xfer", xfer_count, 0);
        vin = rand_vec();
        send(vin, 1'b0, 1, 0, vres);
        chk_vec("rst_tbl1_identity", vres, vin);
        vin = rand_vec();
        send(vin, 1'b0, 2, 0, vres);
        chk_vec("rst_tbl2_identity", vres, vin);

        // Randomised traffic with cfg writes and occasional resets
        for (int k = 0; k < 600; k++) begin
            reset     = ($urandom_range(0, 99) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_data   = rand_vec();
            in_mode   = 1'($urandom);
            in_sel    = 2'($urandom);
            in_rot    = 5'($urandom);
            cfg_valid = ($urandom_range(0, 2) == 0);
            cfg_entry = 2'($urandom);
            cfg_lane  = 5'($urandom);
            cfg_idx   = 5'($urandom);
            tick();
        end
        reset = 1'b0; in_valid = 1'b0; cfg_valid = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        chk("rand_drained", exp_q.size(), 0);

        // Counter wrap from 0xFFFF to 0 under full throughput
        in_valid = 1'b1; in_mode = 1'b1; in_rot = 5'd1; in_data = rand_vec();
        saw_ffff = 1'b0;
        n = 0;
        while (!(saw_ffff && exp_xfer == 16'd0) && n < 70000) begin
            if (exp_xfer == 16'hFFFF) saw_ffff = 1'b1;
            tick();
            n++;
        end
        chk("wrap_xfer_count", xfer_count, 0);
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        chk("wrap_after_drain", xfer_count, exp_xfer);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
